// File: rtl/pipe_pkg.sv
//==============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the pipeline hazard controller.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package pipe_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    // A load in EX feeding a source of the ID instruction; x0 is never a hazard.
    function automatic logic load_use(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       uses_rs2
    );
        return mem_read && (rd != REG_X0) &&
               ((rd == rs1) || (uses_rs2 && (rd == rs2)));
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
//==============================================================================
// Module      : hazard_ctrl_if
// Description : Pipeline-status inputs and control/statistics outputs of the
//               hazard controller.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       if_id_rs1;
    logic [4:0]       if_id_rs2;
    logic             if_id_uses_rs2;
    logic             id_ex_MemRead;
    logic [4:0]       id_ex_rd;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             clear_counters;
    logic             PCWrite;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_write;
    logic             mem_wb_write;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
    logic             mem_timeout;

    modport master (
        output if_id_rs1, if_id_rs2, if_id_uses_rs2, id_ex_MemRead, id_ex_rd,
               branch_taken, mem_req, mem_ready, clear_counters,
        input  PCWrite, if_id_write, if_id_flush, id_ex_flush, ex_mem_write,
               mem_wb_write, stall_count, flush_count, mem_timeout
    );

    modport slave (
        input  if_id_rs1, if_id_rs2, if_id_uses_rs2, id_ex_MemRead, id_ex_rd,
               branch_taken, mem_req, mem_ready, clear_counters,
        output PCWrite, if_id_write, if_id_flush, id_ex_flush, ex_mem_write,
               mem_wb_write, stall_count, flush_count, mem_timeout
    );
endinterface

`default_nettype wire

// File: rtl/sat_counter.sv
//==============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones; clear wins over increment.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sat_counter #(
    parameter int W = 16
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         clr,
    input  wire logic         inc,
    output logic [W-1:0]      q
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
//==============================================================================
// Module      : hazard_ctrl
// Description : Load-use stall, branch flush and data-memory wait sequencing
//               for a 5-stage pipeline, with saturating statistics.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  wire logic    clk,
    input  wire logic    reset,
    hazard_ctrl_if.slave hz
);

    localparam int                WAIT_W   = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mw;
    logic              lu;

    assign mw = hz.mem_req && !hz.mem_ready;
    assign lu = load_use(hz.id_ex_MemRead, hz.id_ex_rd, hz.if_id_rs1,
                         hz.if_id_rs2, hz.if_id_uses_rs2);

    // Responses are combinational so a freeze or stall lands in the same cycle.
    always_comb begin
        hz.PCWrite      = 1'b1;
        hz.if_id_write  = 1'b1;
        hz.ex_mem_write = 1'b1;
        hz.mem_wb_write = 1'b1;
        hz.if_id_flush  = 1'b0;
        hz.id_ex_flush  = 1'b0;
        if (reset) begin
            hz.if_id_flush = 1'b1;
            hz.id_ex_flush = 1'b1;
        end else if (mw) begin
            hz.PCWrite      = 1'b0;
            hz.if_id_write  = 1'b0;
            hz.ex_mem_write = 1'b0;
            hz.mem_wb_write = 1'b0;
        end else if (hz.branch_taken) begin
            hz.if_id_flush = 1'b1;
            hz.id_ex_flush = 1'b1;
        end else if (lu) begin
            hz.PCWrite     = 1'b0;
            hz.if_id_write = 1'b0;
            hz.id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RUN;
            wait_cnt       <= '0;
            hz.mem_timeout <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mw) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (!mw) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt != WAIT_MAX) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase

            if (hz.clear_counters) begin
                hz.mem_timeout <= 1'b0;
            end else if ((state == MEM_WAIT) && mw && (wait_cnt == WAIT_MAX)) begin
                hz.mem_timeout <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (hz.clear_counters),
        .inc   (!hz.PCWrite),
        .q     (hz.stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (hz.clear_counters),
        .inc   (hz.id_ex_flush && hz.branch_taken),
        .q     (hz.flush_count)
    );

endmodule

`default_nettype wire
